// File: rtl/spi_pkg.sv
// Shared widths and the FIFO word-entry payload for the SPI read packer.
package spi_pkg;

    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_WIDTH = BYTE_WIDTH * WORD_BYTES;
    localparam int unsigned NBYTES_W   = 3;

    // One packed word as stored in the output FIFO.
    typedef struct packed {
        logic [WORD_WIDTH-1:0] data;
        logic [NBYTES_W-1:0]   nbytes;
        logic                  last;
    } word_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with sticky overflow flag.
// Ports:
//   clk, rstn         clock, async active-low reset
//   clear             synchronous flush (also clears overflow)
//   push, push_data   write request and entry
//   pop               read request (ignored when empty)
//   head              entry at the head of the FIFO
//   valid             FIFO holds at least one entry
//   level             occupied entries, 0..DEPTH
//   overflow          sticky: a push was dropped because the FIFO was full
module sync_fifo_fwft
    import spi_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LVL_W   = $clog2(DEPTH) + 1,
    parameter type         entry_t = word_entry_t
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             valid,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic [LVL_W-1:0] count_n;
    logic             full;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;
    logic             drop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full    = (count == LVL_W'(DEPTH));
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && !push_ok;
        count_n = count;
        if (push_ok && !pop_ok) begin
            count_n = count + LVL_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_n = count - LVL_W'(1);
        end
    end

    // Storage, pointers, level and flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_n;
            valid <= (count_n != '0);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/spi_read_packer.sv
// Packs bytes from an SPI reader big-endian into 32-bit words, tags partial
// and transaction-final words, and buffers them in a FWFT FIFO.
// Ports:
//   clk, rstn          clock, async active-low reset
//   byte_in/byte_valid byte from the reader; accepted on byte_valid rising edge
//   xfer_done          transaction end; acted on at its rising edge
//   clear              synchronous flush of FIFO, packer and overflow
//   m_data/m_nbytes/m_last/m_valid/m_ready  word output stream
//   fifo_level         occupied FIFO entries
//   overflow           sticky dropped-word flag
module spi_read_packer
    import spi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    input  logic                  byte_valid,
    input  logic                  xfer_done,
    input  logic                  clear,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic [NBYTES_W-1:0]   m_nbytes,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  overflow
);

    logic                  byte_valid_q;
    logic                  xfer_done_q;
    logic [1:0]            idx;
    logic [1:0]            idx_n;
    logic [WORD_WIDTH-1:0] acc;
    logic [WORD_WIDTH-1:0] acc_n;
    logic [WORD_WIDTH-1:0] packed_w;
    logic [NBYTES_W-1:0]   cnt;
    logic                  byte_acc;
    logic                  end_ev;
    logic                  push;
    word_entry_t           push_word;
    word_entry_t           head;

    // Rising-edge detect; a clear swallows any same-cycle edges.
    assign byte_acc = byte_valid && !byte_valid_q && !clear;
    assign end_ev   = xfer_done && !xfer_done_q && !clear;

    // The byte is merged first so an end in the same cycle sees it.
    always_comb begin
        packed_w  = acc;
        idx_n     = idx;
        acc_n     = acc;
        push      = 1'b0;
        push_word = '0;
        if (byte_acc) begin
            case (idx)
                2'd0:    packed_w[31:24] = byte_in;
                2'd1:    packed_w[23:16] = byte_in;
                2'd2:    packed_w[15:8]  = byte_in;
                default: packed_w[7:0]   = byte_in;
            endcase
        end
        cnt = NBYTES_W'(idx) + NBYTES_W'(byte_acc);
        if (end_ev) begin
            // cnt of 0 yields the empty end marker since acc is zero at index 0.
            push             = 1'b1;
            push_word.data   = packed_w;
            push_word.nbytes = cnt;
            push_word.last   = 1'b1;
            idx_n            = 2'd0;
            acc_n            = '0;
        end else if (byte_acc) begin
            if (idx == 2'd3) begin
                push             = 1'b1;
                push_word.data   = packed_w;
                push_word.nbytes = NBYTES_W'(WORD_BYTES);
                push_word.last   = 1'b0;
                idx_n            = 2'd0;
                acc_n            = '0;
            end else begin
                idx_n = idx + 2'd1;
                acc_n = packed_w;
            end
        end
    end

    // Edge registers always track inputs; packer state obeys clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_valid_q <= 1'b0;
            xfer_done_q  <= 1'b0;
            idx          <= 2'd0;
            acc          <= '0;
        end else begin
            byte_valid_q <= byte_valid;
            xfer_done_q  <= xfer_done;
            if (clear) begin
                idx <= 2'd0;
                acc <= '0;
            end else begin
                idx <= idx_n;
                acc <= acc_n;
            end
        end
    end

    sync_fifo_fwft #(
        .DEPTH   (FIFO_DEPTH),
        .LVL_W   (LVL_W),
        .entry_t (word_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .push      (push),
        .push_data (push_word),
        .pop       (m_ready),
        .head      (head),
        .valid     (m_valid),
        .level     (fifo_level),
        .overflow  (overflow)
    );

    assign m_data   = head.data;
    assign m_nbytes = head.nbytes;
    assign m_last   = head.last;

endmodule

// File: doc/spi_read_packer.md
SPI_READ_PACKER -- requirements
Module: spi_read_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, word FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter LVL_W, default $clog2(FIFO_DEPTH)+1, fifo_level width.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 byte_in  input  8  byte from SPI reader, valid when byte_valid rises.
REQ-006 byte_valid  input  1  byte-complete strobe from SPI reader.
REQ-007 xfer_done  input  1  read-transaction-complete strobe from SPI reader.
REQ-008 clear  input  1  synchronous flush request.
REQ-009 m_data  output  32  packed word, first byte in [31:24].
REQ-010 m_nbytes  output  3  valid bytes in m_data, 0..4.
REQ-011 m_last  output  1  word ends the transaction.
REQ-012 m_valid  output  1  output word available.
REQ-013 m_ready  input  1  consumer accepts word.
REQ-014 fifo_level  output  LVL_W  occupied entries, 0..FIFO_DEPTH.
REQ-015 overflow  output  1  sticky word-dropped flag.

Function
REQ-016 Byte accept SHALL occur in a cycle where byte_valid=1 and registered prior byte_valid=0; level-held byte_valid SHALL accept once.
REQ-017 Transaction end SHALL likewise be the rising edge of xfer_done.
REQ-018 Accepted bytes SHALL pack big-endian: byte index 0->[31:24], 1->[23:16], 2->[15:8], 3->[7:0]; 2-bit index increments per accept, wraps 3->0.
REQ-019 At index 3 accept, word SHALL be pushed with nbytes=4, last=0, on that clock edge; m_valid SHALL rise next cycle if FIFO was empty.
REQ-020 Byte accept and xfer_done edge in same cycle: byte SHALL be packed first, then end processing applied.
REQ-021 End with partial word (1..3 bytes incl. same-cycle byte): push zero-padded word, nbytes=count, last=1.
REQ-022 End completing a full word same cycle: that word SHALL carry last=1.
REQ-023 End with index 0 and no same-cycle byte: push marker word data=0, nbytes=0, last=1.
REQ-024 After any end push, index SHALL return to 0 and accumulator to 0.
REQ-025 Output SHALL be first-word-fall-through; pop on m_valid&&m_ready; m_data/m_nbytes/m_last stable while m_valid=1 and m_ready=0.
REQ-026 m_valid SHALL not deassert without a pop or clear.
REQ-027 Push when full without same-cycle pop: word dropped, overflow set until clear or reset; push+pop when full SHALL succeed.
REQ-028 Pop when empty SHALL be ignored; fifo_level SHALL never underflow.
REQ-029 clear=1 SHALL empty FIFO, zero accumulator/index, clear overflow; same-cycle byte/end edges discarded, edge-detect registers still updated.
REQ-030 fifo_level SHALL reflect push/pop on the edge they occur.

Reset
REQ-031 On rstn low: m_valid=0, m_data=0, m_nbytes=0, m_last=0, fifo_level=0, overflow=0, index=0, accumulator=0, edge registers=0.
REQ-032 Reset mid-transaction SHALL discard partial word and FIFO contents; no push on release.

Structure
REQ-033 Package spi_pkg SHALL hold BYTE_WIDTH=8, WORD_BYTES=4, and typedef struct word entry {data[31:0], nbytes[2:0], last}.
REQ-034 Storage SHALL be sub-module sync_fifo_fwft (parameterised depth/entry type); packer/edge logic in top.

Verification
REQ-035 Bytes 0x11,0x22,0x33,0x44 then xfer_done with 4th -> one word 0x11223344, nbytes=4, last=1.
REQ-036 Bytes 0xA1..0xA6, xfer_done after -> 0xA1A2A3A4 last=0 nbytes=4, then 0xA5A60000 nbytes=2 last=1.
REQ-037 xfer_done alone, index 0 -> data=0, nbytes=0, last=1.
REQ-038 m_ready=0, 40 bytes (10 words), depth 8 -> fifo_level=8, overflow=1, first 8 words intact in order.
REQ-039 byte_valid held high 5 cycles -> single byte accepted; clear mid-word then 4 bytes -> first word from post-clear bytes only.
REQ-040 rstn asserted after 2 bytes -> all outputs 0; after release, 4 new bytes -> single correct word.
